ddr_cmd_issuer: RTL
===================

DDR_CMD_ISSUER -- requirements
Module: ddr_cmd_issuer

Interface
REQ-001 Parameters: ADDRWIDTH=17, row/A width; BANKGROUPS=4; BANKSPERGROUP=4; COLS=1024; TRCD=4, ACT-to-RD/WR cycles; TRP=4, PRE-to-ACT cycles; TREFI=64, refresh interval cycles; TRFC=8, REF-to-next-command cycles. BGWIDTH=$clog2(BANKGROUPS), BAWIDTH=$clog2(BANKSPERGROUP), CADDRWIDTH=$clog2(COLS).
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  request present; req_ready  out  1  request accepted when both high on a clk edge.
REQ-005 req_we  in  1  1=write, 0=read; req_bg  in  BGWIDTH; req_ba  in  BAWIDTH; req_row  in  ADDRWIDTH; req_col  in  CADDRWIDTH.
REQ-006 cmd_done  out  1  one-cycle pulse in the cycle the RD or WR for the accepted request is driven.
REQ-007 cke  out  1; cs_n  out  1; act_n  out  1; A  out  ADDRWIDTH; ba  out  BAWIDTH; bg  out  BGWIDTH. All DDR4 command pins registered.

Function
REQ-008 Encoding (A16=RAS_n, A15=CAS_n, A14=WE_n, A10=AP/all): DES: cs_n=1, act_n=1, A=0. ACT: cs_n=0, act_n=0, A=row. RD: act_n=1, A16..14=1,0,1, A10=0, A[CADDRWIDTH-1:0]=col. WR: as RD with A14=0. PRE: A16..14=0,1,0, A10=0, target ba/bg. PREA: as PRE with A10=1. REF: A16..14=0,0,1.
REQ-009 Every command is asserted for exactly one cycle; DES in all other cycles.
REQ-010 Open-row table: one valid bit plus row per bank (BANKGROUPS*BANKSPERGROUP entries); ACT sets the entry; PRE clears it; PREA clears all entries.
REQ-011 FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, REFPA, REFPA_WAIT, REF, REF_WAIT.
REQ-012 req_ready=1 only in IDLE with no refresh pending; one request in flight; request fields latched on accept.
REQ-013 Accept at cycle N: row hit -> RD/WR at N+1. Bank closed -> ACT at N+1, RD/WR at N+1+TRCD. Row conflict -> PRE at N+1, ACT at N+1+TRP, RD/WR at N+1+TRP+TRCD.
REQ-014 cmd_done is high in the RW cycle; FSM returns to IDLE on the next cycle.
REQ-015 Refresh counter free-runs 0..TREFI-1, wraps to 0; at wrap it sets ref_pending, cleared when REF is issued. A wrap while ref_pending is already set is not counted twice.
REQ-016 In IDLE, ref_pending takes priority over req_valid. If any bank is open: PREA, wait TRP, then REF. If none open: REF next cycle. After REF, wait TRFC cycles before returning to IDLE.
REQ-017 ref_pending set mid-request does not abort the request; refresh starts from IDLE afterwards.
REQ-018 Wait states count down from the parameter; a parameter value of 1 means the next command follows in the next cycle.

Reset
REQ-019 While rst=1, outputs are: cke=0, cs_n=1, act_n=1, A=0, ba=0, bg=0, req_ready=0, cmd_done=0. State is IDLE, the open-row table is all invalid, and the refresh counter and ref_pending are 0.
REQ-020 cke=1 from the first clk edge after rst deasserts; req_ready may rise on the same edge.
REQ-021 rst asserted mid-operation aborts immediately to reset values; the in-flight request is dropped and no cmd_done is generated.

Verification
REQ-022 Read to closed bank bg=1, ba=2, row=0x1234, col=0x05A, accepted at cycle 10 -> ACT at 11 with A=0x1234, then RD at 15 with A[9:0]=0x05A, A10=0, cmd_done at 15.
REQ-023 Write hit, row 0x1234 already open in bg=1, ba=2, accepted at cycle 20 -> WR at 21, cmd_done at 21, no ACT issued.
REQ-024 Read to row 0x0777 in the same bank, accepted at 30 -> PRE at 31, ACT at 35 with A=0x0777, RD at 39.
REQ-025 Refresh with a bank open: refresh counter wraps with req_valid high -> req_ready=0, then PREA (A10=1), REF 4 cycles later, IDLE 8 cycles after REF, then the request is accepted.
REQ-026 rst pulsed between ACT and RD -> no RD issued, all outputs at reset values, the open-row table cleared (the next access to that bank issues ACT).
REQ-027 Back-to-back hits with req_valid held high -> a new accept every 2 cycles, each RD/WR the cycle after its accept; cs_n=1 on all non-command cycles.

Source files
------------

// File: rtl/ddr_cmd_issuer_if.sv
// Request handshake and DDR4 command pins shared by ddr_cmd_issuer and its requester.
// The master modport is the requester side; the slave modport is the issuer side.
interface ddr_cmd_issuer_if #(
    parameter int ADDRWIDTH  = 17,
    parameter int BGWIDTH    = 2,
    parameter int BAWIDTH    = 2,
    parameter int CADDRWIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BGWIDTH-1:0]    req_bg;
    logic [BAWIDTH-1:0]    req_ba;
    logic [ADDRWIDTH-1:0]  req_row;
    logic [CADDRWIDTH-1:0] req_col;
    logic                  cmd_done;
    logic                  cke;
    logic                  cs_n;
    logic                  act_n;
    logic [ADDRWIDTH-1:0]  A;
    logic [BAWIDTH-1:0]    ba;
    logic [BGWIDTH-1:0]    bg;

    modport master (
        output req_valid, req_we, req_bg, req_ba, req_row, req_col,
        input  req_ready, cmd_done, cke, cs_n, act_n, A, ba, bg
    );

    modport slave (
        input  req_valid, req_we, req_bg, req_ba, req_row, req_col,
        output req_ready, cmd_done, cke, cs_n, act_n, A, ba, bg
    );
endinterface

// File: rtl/ddr_cmd_issuer.sv
// Single-request DDR4 command issuer: tracks open rows per bank, issues PRE/ACT/RD/WR
// with tRP/tRCD spacing and interleaves periodic all-bank refresh between requests.
module ddr_cmd_issuer #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 4,
    parameter int BANKSPERGROUP = 4,
    parameter int COLS          = 1024,
    parameter int TRCD          = 4,
    parameter int TRP           = 4,
    parameter int TREFI         = 64,
    parameter int TRFC          = 8,
    parameter int BGWIDTH       = $clog2(BANKGROUPS),
    parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
    parameter int CADDRWIDTH    = $clog2(COLS)
) (
    input logic             clk,
    input logic             rst,
    ddr_cmd_issuer_if.slave bus
);
    localparam int NBANKS  = BANKGROUPS * BANKSPERGROUP;
    localparam int BIDXW   = BGWIDTH + BAWIDTH;
    localparam int MAXWAIT = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                          : ((TRP > TRFC) ? TRP : TRFC);
    localparam int WAITW   = $clog2(MAXWAIT + 1);
    localparam int REFW    = (TREFI > 1) ? $clog2(TREFI) : 1;

    localparam int A_RAS = 16;
    localparam int A_CAS = 15;
    localparam int A_WE  = 14;
    localparam int A_AP  = 10;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_PRE        = 4'd1;
    localparam logic [3:0] ST_PRE_WAIT   = 4'd2;
    localparam logic [3:0] ST_ACT        = 4'd3;
    localparam logic [3:0] ST_ACT_WAIT   = 4'd4;
    localparam logic [3:0] ST_RW         = 4'd5;
    localparam logic [3:0] ST_REFPA      = 4'd6;
    localparam logic [3:0] ST_REFPA_WAIT = 4'd7;
    localparam logic [3:0] ST_REF        = 4'd8;
    localparam logic [3:0] ST_REF_WAIT   = 4'd9;

    logic [3:0]            state_q, state_d;
    logic [WAITW-1:0]      waitCnt_q, waitCnt_d;
    logic [REFW-1:0]       refCnt_q;
    logic                  refPending_q;
    logic                  cke_q;

    logic                  reqWe_q, reqWe_d;
    logic [BGWIDTH-1:0]    reqBg_q, reqBg_d;
    logic [BAWIDTH-1:0]    reqBa_q, reqBa_d;
    logic [ADDRWIDTH-1:0]  reqRow_q, reqRow_d;
    logic [CADDRWIDTH-1:0] reqCol_q, reqCol_d;

    logic [NBANKS-1:0]     openValid_q;
    logic [ADDRWIDTH-1:0]  openRow_q [NBANKS];

    logic                  csN_q, csN_d;
    logic                  actN_q, actN_d;
    logic [ADDRWIDTH-1:0]  a_q, a_d;
    logic [BAWIDTH-1:0]    ba_q, ba_d;
    logic [BGWIDTH-1:0]    bg_q, bg_d;
    logic                  cmdDone_q, cmdDone_d;

    logic [BIDXW-1:0]      inIdx;
    logic [BIDXW-1:0]      curIdx;
    logic                  reqReady;
    logic                  accept;
    logic                  refWrap;

    assign inIdx    = {bus.req_bg, bus.req_ba};
    assign curIdx   = {reqBg_d, reqBa_d};
    assign reqReady = (state_q == ST_IDLE) && !refPending_q && cke_q;
    assign accept   = reqReady && bus.req_valid;
    assign refWrap  = (refCnt_q == REFW'(TREFI - 1));

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        reqWe_d   = reqWe_q;
        reqBg_d   = reqBg_q;
        reqBa_d   = reqBa_q;
        reqRow_d  = reqRow_q;
        reqCol_d  = reqCol_q;
        case (state_q)
            ST_IDLE: begin
                if (cke_q && refPending_q) begin
                    if (|openValid_q) begin
                        state_d   = ST_REFPA;
                        waitCnt_d = WAITW'(TRP - 1);
                    end else begin
                        state_d   = ST_REF;
                        waitCnt_d = WAITW'(TRFC - 1);
                    end
                end else if (accept) begin
                    reqWe_d  = bus.req_we;
                    reqBg_d  = bus.req_bg;
                    reqBa_d  = bus.req_ba;
                    reqRow_d = bus.req_row;
                    reqCol_d = bus.req_col;
                    if (openValid_q[inIdx] && (openRow_q[inIdx] == bus.req_row)) begin
                        state_d = ST_RW;
                    end else if (openValid_q[inIdx]) begin
                        state_d   = ST_PRE;
                        waitCnt_d = WAITW'(TRP - 1);
                    end else begin
                        state_d   = ST_ACT;
                        waitCnt_d = WAITW'(TRCD - 1);
                    end
                end
            end
            // Each command state counts the remaining gap; zero means the next command follows.
            ST_PRE, ST_PRE_WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d   = ST_ACT;
                    waitCnt_d = WAITW'(TRCD - 1);
                end else begin
                    state_d   = ST_PRE_WAIT;
                    waitCnt_d = waitCnt_q - WAITW'(1);
                end
            end
            ST_ACT, ST_ACT_WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d = ST_RW;
                end else begin
                    state_d   = ST_ACT_WAIT;
                    waitCnt_d = waitCnt_q - WAITW'(1);
                end
            end
            ST_RW: begin
                state_d = ST_IDLE;
            end
            ST_REFPA, ST_REFPA_WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d   = ST_REF;
                    waitCnt_d = WAITW'(TRFC - 1);
                end else begin
                    state_d   = ST_REFPA_WAIT;
                    waitCnt_d = waitCnt_q - WAITW'(1);
                end
            end
            ST_REF, ST_REF_WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_REF_WAIT;
                    waitCnt_d = waitCnt_q - WAITW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so each command is registered on entry to its state.
    always_comb begin
        csN_d     = 1'b1;
        actN_d    = 1'b1;
        a_d       = '0;
        ba_d      = '0;
        bg_d      = '0;
        cmdDone_d = (state_d == ST_RW);
        case (state_d)
            ST_ACT: begin
                csN_d  = 1'b0;
                actN_d = 1'b0;
                a_d    = reqRow_d;
                ba_d   = reqBa_d;
                bg_d   = reqBg_d;
            end
            ST_RW: begin
                csN_d                 = 1'b0;
                a_d[A_RAS]            = 1'b1;
                a_d[A_WE]             = ~reqWe_d;
                a_d[CADDRWIDTH-1:0]   = reqCol_d;
                ba_d                  = reqBa_d;
                bg_d                  = reqBg_d;
            end
            ST_PRE: begin
                csN_d      = 1'b0;
                a_d[A_CAS] = 1'b1;
                ba_d       = reqBa_d;
                bg_d       = reqBg_d;
            end
            ST_REFPA: begin
                csN_d      = 1'b0;
                a_d[A_CAS] = 1'b1;
                a_d[A_AP]  = 1'b1;
            end
            ST_REF: begin
                csN_d     = 1'b0;
                a_d[A_WE] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            waitCnt_q    <= '0;
            refCnt_q     <= '0;
            refPending_q <= 1'b0;
            cke_q        <= 1'b0;
            reqWe_q      <= 1'b0;
            reqBg_q      <= '0;
            reqBa_q      <= '0;
            reqRow_q     <= '0;
            reqCol_q     <= '0;
            openValid_q  <= '0;
            for (int i = 0; i < NBANKS; i++) begin
                openRow_q[i] <= '0;
            end
            csN_q        <= 1'b1;
            actN_q       <= 1'b1;
            a_q          <= '0;
            ba_q         <= '0;
            bg_q         <= '0;
            cmdDone_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            refCnt_q     <= refWrap ? '0 : refCnt_q + REFW'(1);
            refPending_q <= refWrap | (refPending_q & (state_d != ST_REF));
            cke_q        <= 1'b1;
            reqWe_q      <= reqWe_d;
            reqBg_q      <= reqBg_d;
            reqBa_q      <= reqBa_d;
            reqRow_q     <= reqRow_d;
            reqCol_q     <= reqCol_d;
            if (state_d == ST_REFPA) begin
                openValid_q <= '0;
            end else if (state_d == ST_PRE) begin
                openValid_q[curIdx] <= 1'b0;
            end else if (state_d == ST_ACT) begin
                openValid_q[curIdx] <= 1'b1;
                openRow_q[curIdx]   <= reqRow_d;
            end
            csN_q        <= csN_d;
            actN_q       <= actN_d;
            a_q          <= a_d;
            ba_q         <= ba_d;
            bg_q         <= bg_d;
            cmdDone_q    <= cmdDone_d;
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.cmd_done  = cmdDone_q;
    assign bus.cke       = cke_q;
    assign bus.cs_n      = csN_q;
    assign bus.act_n     = actN_q;
    assign bus.A         = a_q;
    assign bus.ba        = ba_q;
    assign bus.bg        = bg_q;
endmodule
